// File: rtl/wb_regfile_commit_if.sv
// rtl/wb_regfile_commit_if.sv - W-stage commit bus and decode read-port bundle
//
// Purpose: groups the W pipeline register fields, the two decode read ports and the
//          architectural status outputs of wb_regfile_commit into one bundle.
// Parameter: CNT_W - width of the retired-instruction counter (must match the DUT).
// Signals:
//   W_stall, W_stat[3:0], W_icode[3:0], W_ValE[63:0], W_ValM[63:0], W_dstE[3:0], W_dstM[3:0]
//   d_srcA[3:0], d_srcB[3:0]        read addresses      (master -> slave)
//   d_rvalA[63:0], d_rvalB[63:0]    read data           (slave -> master)
//   Stat[3:0], halted, retired      architectural state (slave -> master)
// Modports: master = pipeline/decode side, slave = writeback block.

interface wb_regfile_commit_if #(
   parameter int unsigned CNT_W = 32
);
   logic             W_stall;
   logic [3:0]       W_stat;
   logic [3:0]       W_icode;
   logic [63:0]      W_ValE;
   logic [63:0]      W_ValM;
   logic [3:0]       W_dstE;
   logic [3:0]       W_dstM;
   logic [3:0]       d_srcA;
   logic [3:0]       d_srcB;
   logic [63:0]      d_rvalA;
   logic [63:0]      d_rvalB;
   logic [3:0]       Stat;
   logic             halted;
   logic [CNT_W-1:0] retired;

   modport master (
      output W_stall, W_stat, W_icode, W_ValE, W_ValM, W_dstE, W_dstM, d_srcA, d_srcB,
      input  d_rvalA, d_rvalB, Stat, halted, retired
   );

   modport slave (
      input  W_stall, W_stat, W_icode, W_ValE, W_ValM, W_dstE, W_dstM, d_srcA, d_srcB,
      output d_rvalA, d_rvalB, Stat, halted, retired
   );
endinterface

// File: rtl/wb_regfile_commit.sv
// rtl/wb_regfile_commit.sv - Y86-64 writeback/commit stage with register file and status
//
// Purpose: commits the instruction held in the W pipeline register into the 15-entry
//          register file, serves the two decode read ports, tracks processor status and
//          counts retired non-nop instructions. Architectural state freezes once a
//          halting or faulting instruction commits, until reset.
// Optional feature: WB_BYPASS_EN - when defined, the read ports forward the write being
//          committed this cycle; when undefined, they return stored values only.
// Parameters: RSP_INIT - reset value of %rsp (reg 4); CNT_W - retired counter width.
// Ports:
//   clk    in  clock, all state updates on posedge
//   rst_n  in  synchronous reset, active-low
//   wb     slave modport of wb_regfile_commit_if (W_* commit inputs, d_src/d_rval read
//          ports, Stat/halted/retired status outputs)

module wb_regfile_commit #(
   parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200,
   parameter int unsigned CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   wb_regfile_commit_if.slave wb
);

   localparam logic [3:0] SAOK  = 4'd1;
   localparam logic [3:0] SHLT  = 4'd2;
   localparam logic [3:0] SADR  = 4'd3;
   localparam logic [3:0] SINS  = 4'd4;
   localparam logic [3:0] INOP  = 4'h1;
   localparam logic [3:0] RNONE = 4'hF;
   localparam int         NREGS = 15;

   typedef enum logic {
      S_RUN     = 1'b0,
      S_STOPPED = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic             commit;
   logic             halted;

   logic [63:0]      regs_q [0:NREGS-1];
   logic [63:0]      regs_d [0:NREGS-1];
   logic [3:0]       stat_q, stat_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [63:0]      rval_a, rval_b;

   // Any status code outside the three defined terminating codes is reported as SINS.
   function automatic logic [3:0] term_stat(input logic [3:0] s);
      if (s == SHLT || s == SADR || s == SINS) begin
         return s;
      end
      return SINS;
   endfunction

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (commit && wb.W_stat != SAOK) begin
         state_d = S_STOPPED;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      commit = 1'b0;
      halted = 1'b0;
      commit = (state_q == S_RUN) && !wb.W_stall;
      halted = (state_q == S_STOPPED);
   end

   // ---------------- Commit datapath ----------------
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      stat_d    = stat_q;
      retired_d = retired_q;

      if (commit) begin
         if (wb.W_stat == SAOK) begin
            // Only indices 0..14 exist, so RNONE never matches. ValM is tested first so a
            // shared destination takes the memory value (popq %rsp).
            for (int i = 0; i < NREGS; i++) begin
               if (wb.W_dstM == 4'(i)) begin
                  regs_d[i] = wb.W_ValM;
               end else if (wb.W_dstE == 4'(i)) begin
                  regs_d[i] = wb.W_ValE;
               end
            end
            if (wb.W_icode != INOP) begin
               retired_d = retired_q + CNT_W'(1);
            end
         end else begin
            stat_d = term_stat(wb.W_stat);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= (i == 4) ? RSP_INIT : 64'h0;
         end
         stat_q    <= SAOK;
         retired_q <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         stat_q    <= stat_d;
         retired_q <= retired_d;
      end
   end

   // ---------------- Read ports ----------------
   always_comb begin
      rval_a = 64'h0;
      rval_b = 64'h0;
      for (int i = 0; i < NREGS; i++) begin
         if (wb.d_srcA == 4'(i)) begin
            rval_a = regs_q[i];
         end
         if (wb.d_srcB == 4'(i)) begin
            rval_b = regs_q[i];
         end
      end
`ifdef WB_BYPASS_EN
      // Forward the value being written this cycle; ValM has priority as in the write path.
      if (commit && wb.W_stat == SAOK) begin
         if (wb.d_srcA != RNONE) begin
            if (wb.d_srcA == wb.W_dstM) begin
               rval_a = wb.W_ValM;
            end else if (wb.d_srcA == wb.W_dstE) begin
               rval_a = wb.W_ValE;
            end
         end
         if (wb.d_srcB != RNONE) begin
            if (wb.d_srcB == wb.W_dstM) begin
               rval_b = wb.W_ValM;
            end else if (wb.d_srcB == wb.W_dstE) begin
               rval_b = wb.W_ValE;
            end
         end
      end
`endif
   end

   assign wb.d_rvalA = rval_a;
   assign wb.d_rvalB = rval_b;
   assign wb.Stat    = stat_q;
   assign wb.halted  = halted;
   assign wb.retired = retired_q;

endmodule

// File: tb/tb_wb_regfile_commit.sv
// tb/tb_wb_regfile_commit.sv - self-checking bench for wb_regfile_commit

module tb_wb_regfile_commit;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   wb_regfile_commit_if #(.CNT_W(32)) bus ();
   wb_regfile_commit_if #(.CNT_W(4))  bus4 ();

   wb_regfile_commit #(.RSP_INIT(64'h200), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (bus)
   );

   // Narrow-counter copy sees identical stimulus; used for the wrap check.
   wb_regfile_commit #(.RSP_INIT(64'h200), .CNT_W(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (bus4)
   );

   assign bus4.W_stall = bus.W_stall;
   assign bus4.W_stat  = bus.W_stat;
   assign bus4.W_icode = bus.W_icode;
   assign bus4.W_ValE  = bus.W_ValE;
   assign bus4.W_ValM  = bus.W_ValM;
   assign bus4.W_dstE  = bus.W_dstE;
   assign bus4.W_dstM  = bus.W_dstM;
   assign bus4.d_srcA  = bus.d_srcA;
   assign bus4.d_srcB  = bus.d_srcB;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        stall;
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  dst_e;
      logic [63:0] val_e;
      logic [3:0]  dst_m;
      logic [63:0] val_m;
      logic [3:0]  src_a;
      logic [3:0]  src_b;
      logic [63:0] exp_a;
      logic [63:0] exp_b;
      logic [3:0]  exp_stat;
      logic        exp_halted;
      logic [31:0] exp_ret;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic stall, input logic [3:0] stat, input logic [3:0] icode,
                        input logic [3:0] dst_e, input logic [63:0] val_e,
                        input logic [3:0] dst_m, input logic [63:0] val_m);
      bus.W_stall = stall;
      bus.W_stat  = stat;
      bus.W_icode = icode;
      bus.W_dstE  = dst_e;
      bus.W_ValE  = val_e;
      bus.W_dstM  = dst_m;
      bus.W_ValM  = val_m;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 4'd1, 4'd1, 4'hF, 64'h0, 4'hF, 64'h0);
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk_status(input string tag, input logic [3:0] stat, input logic halted,
                             input logic [31:0] ret);
      chk({tag, "_stat"},    64'(bus.Stat),    64'(stat));
      chk({tag, "_halted"},  64'(bus.halted),  64'(halted));
      chk({tag, "_retired"}, 64'(bus.retired), 64'(ret));
      chk({tag, "_ret4"},    64'(bus4.retired), 64'(ret[3:0]));
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.d_srcA = 4'd4;
      bus.d_srcB = 4'd0;
      drive(1'b0, 4'd1, 4'd1, 4'hF, 64'h0, 4'hF, 64'h0);
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      chk("rst_r4", bus.d_rvalA, 64'h200);
      chk("rst_r0", bus.d_rvalB, 64'h0);
      chk_status("rst", 4'd1, 1'b0, 32'd0);
      bus.d_srcA = 4'hF;
      #1;
      chk("rst_rnone", bus.d_rvalA, 64'h0);

      // Directed commit vectors, state carried from one to the next
      vecs[0] = '{stall:1'b0, stat:4'd1, icode:4'd5, dst_e:4'd2, val_e:64'h11, dst_m:4'd3, val_m:64'h22,
                  src_a:4'd2, src_b:4'd3, exp_a:64'h11, exp_b:64'h22, exp_stat:4'd1, exp_halted:1'b0, exp_ret:32'd1};
      vecs[1] = '{stall:1'b0, stat:4'd1, icode:4'd11, dst_e:4'd4, val_e:64'hAA, dst_m:4'd4, val_m:64'hBB,
                  src_a:4'd4, src_b:4'hF, exp_a:64'hBB, exp_b:64'h0, exp_stat:4'd1, exp_halted:1'b0, exp_ret:32'd2};
      vecs[2] = '{stall:1'b1, stat:4'd1, icode:4'd6, dst_e:4'd1, val_e:64'h5, dst_m:4'hF, val_m:64'h0,
                  src_a:4'd1, src_b:4'd2, exp_a:64'h0, exp_b:64'h11, exp_stat:4'd1, exp_halted:1'b0, exp_ret:32'd2};
      vecs[3] = '{stall:1'b0, stat:4'd1, icode:4'd1, dst_e:4'hF, val_e:64'h0, dst_m:4'hF, val_m:64'h0,
                  src_a:4'd3, src_b:4'd4, exp_a:64'h22, exp_b:64'hBB, exp_stat:4'd1, exp_halted:1'b0, exp_ret:32'd2};
      vecs[4] = '{stall:1'b0, stat:4'd1, icode:4'd1, dst_e:4'd7, val_e:64'h77, dst_m:4'hF, val_m:64'h0,
                  src_a:4'd7, src_b:4'd1, exp_a:64'h77, exp_b:64'h0, exp_stat:4'd1, exp_halted:1'b0, exp_ret:32'd2};
      vecs[5] = '{stall:1'b0, stat:4'd1, icode:4'd6, dst_e:4'd14, val_e:64'hDEAD, dst_m:4'hF, val_m:64'h0,
                  src_a:4'd14, src_b:4'd0, exp_a:64'hDEAD, exp_b:64'h0, exp_stat:4'd1, exp_halted:1'b0, exp_ret:32'd3};
      vecs[6] = '{stall:1'b0, stat:4'd1, icode:4'd5, dst_e:4'hF, val_e:64'h9, dst_m:4'd0, val_m:64'h1234,
                  src_a:4'd0, src_b:4'hF, exp_a:64'h1234, exp_b:64'h0, exp_stat:4'd1, exp_halted:1'b0, exp_ret:32'd4};

      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].stall, vecs[i].stat, vecs[i].icode, vecs[i].dst_e, vecs[i].val_e,
               vecs[i].dst_m, vecs[i].val_m);
         bus.d_srcA = vecs[i].src_a;
         bus.d_srcB = vecs[i].src_b;
         tick();
         chk($sformatf("v%0d_rvalA", i), bus.d_rvalA, vecs[i].exp_a);
         chk($sformatf("v%0d_rvalB", i), bus.d_rvalB, vecs[i].exp_b);
         chk_status($sformatf("v%0d", i), vecs[i].exp_stat, vecs[i].exp_halted, vecs[i].exp_ret);
      end

      // Halt: terminating instr writes nothing and is not counted; later commits ignored
      drive(1'b0, 4'd2, 4'd0, 4'd5, 64'h9, 4'hF, 64'h0);
      bus.d_srcA = 4'd5;
      bus.d_srcB = 4'd0;
      tick();
      chk("hlt_r5", bus.d_rvalA, 64'h0);
      chk_status("hlt", 4'd2, 1'b1, 32'd4);
      drive(1'b0, 4'd1, 4'd5, 4'd0, 64'h7, 4'hF, 64'h0);
      tick();
      chk("hlt_frozen_r0", bus.d_rvalB, 64'h1234);
      chk_status("hlt_frozen", 4'd2, 1'b1, 32'd4);

      // Reset out of STOPPED restores everything
      do_reset();
      bus.d_srcA = 4'd4;
      bus.d_srcB = 4'd2;
      #1;
      chk("rst2_r4", bus.d_rvalA, 64'h200);
      chk("rst2_r2", bus.d_rvalB, 64'h0);
      chk_status("rst2", 4'd1, 1'b0, 32'd0);

      // Address fault, later status ignored, then reset
      drive(1'b0, 4'd3, 4'd5, 4'd5, 64'h9, 4'hF, 64'h0);
      bus.d_srcA = 4'd5;
      tick();
      chk("adr_r5", bus.d_rvalA, 64'h0);
      chk_status("adr", 4'd3, 1'b1, 32'd0);
      drive(1'b0, 4'd4, 4'd5, 4'hF, 64'h0, 4'hF, 64'h0);
      tick();
      chk_status("adr_sticky", 4'd3, 1'b1, 32'd0);
      do_reset();
      chk_status("adr_rst", 4'd1, 1'b0, 32'd0);

      // Undefined status codes report as SINS
      drive(1'b0, 4'd0, 4'd5, 4'd5, 64'h9, 4'hF, 64'h0);
      tick();
      chk("st0_r5", bus.d_rvalA, 64'h0);
      chk_status("st0", 4'd4, 1'b1, 32'd0);
      do_reset();
      drive(1'b0, 4'hA, 4'd5, 4'hF, 64'h0, 4'hF, 64'h0);
      tick();
      chk_status("stA", 4'd4, 1'b1, 32'd0);
      do_reset();

      // Stall blocks a terminating status and a write
      drive(1'b1, 4'd2, 4'd0, 4'hF, 64'h0, 4'hF, 64'h0);
      tick();
      chk_status("stl_hlt", 4'd1, 1'b0, 32'd0);
      drive(1'b1, 4'd1, 4'd5, 4'd1, 64'h5, 4'hF, 64'h0);
      bus.d_srcA = 4'd1;
      tick();
      chk("stl_r1", bus.d_rvalA, 64'h0);
      chk_status("stl_wr", 4'd1, 1'b0, 32'd0);

      // Reset wins over a same-edge commit
      rst_n = 1'b0;
      drive(1'b0, 4'd1, 4'd5, 4'd2, 64'h55, 4'hF, 64'h0);
      bus.d_srcA = 4'd2;
      tick();
      rst_n = 1'b1;
      drive(1'b1, 4'd1, 4'd1, 4'hF, 64'h0, 4'hF, 64'h0);
      #1;
      chk("rstov_r2", bus.d_rvalA, 64'h0);
      chk_status("rstov", 4'd1, 1'b0, 32'd0);

      // Same-cycle read of a pending write
      drive(1'b0, 4'd1, 4'd5, 4'd6, 64'h33, 4'd7, 64'h44);
      bus.d_srcA = 4'd6;
      bus.d_srcB = 4'd7;
      #1;
`ifdef WB_BYPASS_EN
      chk("byp_pre_a", bus.d_rvalA, 64'h33);
      chk("byp_pre_b", bus.d_rvalB, 64'h44);
`else
      chk("byp_pre_a", bus.d_rvalA, 64'h0);
      chk("byp_pre_b", bus.d_rvalB, 64'h0);
`endif
      tick();
      chk("byp_post_a", bus.d_rvalA, 64'h33);
      chk("byp_post_b", bus.d_rvalB, 64'h44);
      chk_status("byp", 4'd1, 1'b0, 32'd1);

      // Counter wrap on the 4-bit instance
      do_reset();
      for (int i = 0; i < 15; i++) begin
         drive(1'b0, 4'd1, 4'd6, 4'hF, 64'h0, 4'hF, 64'h0);
         tick();
      end
      chk("wrap_15", 64'(bus4.retired), 64'd15);
      drive(1'b0, 4'd1, 4'd6, 4'hF, 64'h0, 4'hF, 64'h0);
      tick();
      chk("wrap_0", 64'(bus4.retired), 64'd0);
      chk("wrap_wide", 64'(bus.retired), 64'd16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
